// File: rtl/i2c_pkg.sv
// Shared constants for the I2C transmit bit driver:
// FSM encoding, ACK polarity and byte geometry.
package i2c_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT    = 2'd1;
    localparam logic [1:0] ST_ACK_WAIT = 2'd2;
    localparam logic [1:0] ST_ACK_END  = 2'd3;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int BITS_PER_BYTE = 8;
    localparam logic [2:0] MSB_IDX = 3'(BITS_PER_BYTE - 1);

endpackage

// File: rtl/i2c_input_sync.sv
// Pad-input synchroniser chain with single-cycle
// rise/fall pulses derived from the synchronised level.
module i2c_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Reset to 1: an idle I2C bus sits high.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], raw};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = ~prev & sync;
    assign fall = prev & ~sync;

endmodule

// File: rtl/i2c_tx_bit_driver.sv
// Serialises a handshaked byte onto open-drain SDA, MSB
// first on SCL falls, then samples the master's ACK bit.
module i2c_tx_bit_driver
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       abort,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       sda_oe,
    output logic       busy,
    output logic       ack_valid,
    output logic       ack_nack
);

    logic [1:0] state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    logic scl_level_unused;
    logic scl_rise;
    logic scl_fall;
    logic sda_sync;
    logic sda_rise_unused;
    logic sda_fall_unused;

    i2c_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (scl_in),
        .sync  (scl_level_unused),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (sda_in),
        .sync  (sda_sync),
        .rise  (sda_rise_unused),
        .fall  (sda_fall_unused)
    );

    assign busy     = (state != ST_IDLE);
    assign tx_ready = (state == ST_IDLE) & ~abort;

    // sda_oe is registered: it follows bit_cnt one cycle
    // after the decrement, keeping the pad output glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= MSB_IDX;
            sda_oe    <= 1'b0;
            ack_valid <= 1'b0;
            ack_nack  <= ACK;
        end else begin
            ack_valid <= 1'b0;
            if (abort) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                        if (tx_valid && tx_ready) begin
                            shreg   <= tx_data;
                            bit_cnt <= MSB_IDX;
                            sda_oe  <= ~tx_data[MSB_IDX];
                            state   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (scl_fall && bit_cnt == 3'd0) begin
                            sda_oe <= 1'b0;
                            state  <= ST_ACK_WAIT;
                        end else begin
                            sda_oe <= ~shreg[bit_cnt];
                            if (scl_fall)
                                bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                    ST_ACK_WAIT: begin
                        sda_oe <= 1'b0;
                        if (scl_rise) begin
                            ack_valid <= 1'b1;
                            ack_nack  <= sda_sync ? NACK : ACK;
                            state     <= ST_ACK_END;
                        end
                    end
                    ST_ACK_END: begin
                        sda_oe <= 1'b0;
                        if (scl_fall)
                            state <= ST_IDLE;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
